regfile_dump_reader: RTL and testbench
======================================

# regfile_dump_reader

Debug/trace block that reads out the CPU register file. On a `start` pulse it walks register indices 0..NUM_REGS-1 through one register-file read port and streams each (index, value) pair over a valid/ready handshake to a trace or host interface. It sits beside the register file and shares a read-address port with it through an external mux, which `busy` selects. It never writes the register file.

## Interface
- NUM_REGS, 32, number of registers to dump; must be a power of two, at least 2 and at most 2^ADDR_W
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs
- start  input  1  request a full dump; sampled only in IDLE
- abort  input  1  cancel an in-progress dump; returns to IDLE with no `done` pulse
- rd_addr  output  ADDR_W  register-file read address (combinational read port)
- rd_data  input  DATA_W  register-file read data for `rd_addr`, valid in the same cycle
- busy  output  1  high in READ and SEND; steers the external read-port mux
- out_valid  output  1  `out_index`/`out_data` hold a valid pair
- out_ready  input  1  consumer accepts the pair when `out_valid & out_ready` at a rising edge
- out_index  output  ADDR_W  register index of the current pair
- out_data  output  DATA_W  captured register value
- done  output  1  single-cycle pulse after the last pair is accepted

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - `start & !abort` -> READ, with idx=0.
  - `abort` has priority over `start`; the block stays in IDLE.
- READ:
  - `rd_addr`=idx.
  - At the next edge, `out_data`<=`rd_data` and `out_index`<=idx; go to SEND.
- SEND:
  - `out_valid`=1; `out_data`/`out_index` stay stable until accepted.
  - On accept with idx==NUM_REGS-1 -> DONE.
  - On accept otherwise -> idx+1, then READ.
  - With no accept, stay in SEND indefinitely; there is no timeout.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `abort` in READ, SEND or DONE -> IDLE at the next edge.
  - `out_valid`, `busy` and `done` are 0 from that edge on.
  - A pair that is accepted on the same edge as `abort` counts as delivered; the dump still ends.
- `start` while not in IDLE is ignored, including in the DONE cycle.
- idx is ADDR_W bits wide and never exceeds NUM_REGS-1, so no wrap-around occurs.
- `rd_addr`=idx in every state. idx is 0 in IDLE, so `rd_addr`=0 there.
- The dump is not a snapshot. Each register is sampled at the READ-exit edge, so a write the register file completes (falling edge) before that edge is visible in the dump.
- x0 is dumped like any other register; the register file supplies 0 for it.

## Timing
- Reset values:
  - state=IDLE, idx=0, rd_addr=0
  - busy=0, out_valid=0, out_index=0, out_data=0, done=0
- `reset` takes effect immediately (asynchronously) and overrides every state, including mid-handshake.
- Outputs are registered or decoded from state only. There is no combinational path from `out_ready` or `start` to any output.
- Edge-by-edge sequence for a start at edge E0:
  - After E0: READ, idx 0.
  - After E1: SEND, pair 0 valid.
  - Each pair takes 2 cycles plus any stall cycles.
- With `out_ready` held high:
  - Last accept at E(2·NUM_REGS).
  - `done` high from E(2·NUM_REGS) to E(2·NUM_REGS+1).
  - For NUM_REGS=32 that is E64..E65.
- `busy` falls at the same edge that DONE is entered.

## Test plan
- Reset, then register file preloaded with x_i=i·0x11111111, `out_ready`=1, one-cycle `start` at E0 -> 32 pairs (i, i·0x11111111) in order, first `out_valid` after E1, `done` high exactly at cycle E64..E65, `busy` low from E64.
- Same preload with `out_ready` toggling 1,0,0,1,... -> identical sequence, no duplicates or drops, and `out_data` stable throughout every stall.
- Write x5=0xDEADBEEF while the dump is stalled in SEND on index 3 -> dumped x5 equals 0xDEADBEEF.
- `abort` asserted while in SEND on index 10 with `out_ready`=0 -> IDLE next edge, `out_valid`=0, no `done`; a later `start` restarts the dump at index 0.
- `start` pulsed mid-dump and `start`+`abort` together in IDLE -> ignored in both cases: the dump does not restart, and the block stays IDLE with `busy`=0.
- Asynchronous `reset` between edges during SEND on index 7 -> all outputs 0 immediately, state IDLE, no `done` pulse.

Source files
------------

// File: rtl/regfile_dump_if.sv
// regfile_dump_if: control, register-file read port and trace handshake of the dump reader.
interface regfile_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;
  logic              done;
  modport master (
    input  start, abort, rd_data, out_ready,
    output rd_addr, busy, out_valid, out_index, out_data, done
  );
  modport slave (
    output start, abort, rd_data, out_ready,
    input  rd_addr, busy, out_valid, out_index, out_data, done
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks the register file through one read port and streams (index, value) pairs.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic clk,
  input  logic reset,
  regfile_dump_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, out_index_q, out_index_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              busy_q, busy_d, out_valid_q, out_valid_d, done_q, done_d;
  logic              last, accept;
  assign last   = idx_q == ADDR_W'(NUM_REGS - 1);
  assign accept = out_valid_q & bus.out_ready;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    if (state_q != IDLE && bus.abort) begin
      state_d     = IDLE;
      idx_d       = '0;
      busy_d      = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start && !bus.abort) begin
          state_d = READ;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
        READ: begin
          state_d     = SEND;
          out_data_d  = bus.rd_data;
          out_index_d = idx_q;
          out_valid_d = 1'b1;
        end
        SEND: if (accept) begin
          out_valid_d = 1'b0;
          // idx returns to 0 on the last pair so rd_addr idles at x0
          state_d     = last ? DONE : READ;
          idx_d       = last ? '0 : idx_q + ADDR_W'(1);
          busy_d      = !last;
          done_d      = last;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end
  assign bus.rd_addr   = idx_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = out_index_q;
  assign bus.out_data  = out_data_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: scoreboard bench; a register-file array feeds the read port, a monitor checks pairs.
module tb_regfile_dump_reader;
  localparam int N = 32;
  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } pair_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] regs [N];
  pair_t       q [$];
  pair_t       p;
  int          n_cmp = 0, n_err = 0, done_cnt = 0, exp_done = 0;
  int          cyc = 0, e0 = 0;
  bit          timing_on = 1'b0;
  logic        prev_valid = 1'b0, prev_acc = 1'b0;
  logic [4:0]  prev_idx = '0;
  logic [31:0] prev_data = '0;
  regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) bus ();
  regfile_dump_reader #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  assign bus.rd_data = regs[bus.rd_addr];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endfunction
  function automatic void push_dump();
    for (int i = 0; i < N; i++) q.push_back('{idx: 5'(i), data: regs[i]});
  endfunction
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.out_valid && prev_valid && !prev_acc) begin
      check("stall_index", 64'(bus.out_index), 64'(prev_idx));
      check("stall_data", 64'(bus.out_data), 64'(prev_data));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pair: got index %0d, required no pair", bus.out_index);
      end else begin
        p = q.pop_front();
        check("pair_index", 64'(bus.out_index), 64'(p.idx));
        check("pair_data", 64'(bus.out_data), 64'(p.data));
      end
    end
    if (timing_on) begin
      if (cyc - e0 == 0)  check("e0_valid_low", 64'(bus.out_valid), 0);
      if (cyc - e0 == 1)  check("e1_first_valid", 64'(bus.out_valid), 1);
      if (cyc - e0 == 63) check("e63_busy", 64'({bus.busy, bus.done}), 64'b10);
      if (cyc - e0 == 64) check("e64_done_busy", 64'({bus.busy, bus.done}), 64'b01);
      if (cyc - e0 == 65) check("e65_done_low", 64'(bus.done), 0);
    end
    prev_valid = bus.out_valid;
    prev_acc   = bus.out_valid && bus.out_ready;
    prev_idx   = bus.out_index;
    prev_data  = bus.out_data;
  end
  task automatic pulse_start();
    @(posedge clk); #1;
    e0 = cyc + 1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask
  // mode 0: ready high, 1: ready 1,0,0 pattern, 2: random ready, 3: ready high plus a stray start
  task automatic finish_dump(input int mode);
    for (int k = 0; k < 2000; k++) begin
      if (!bus.busy) break;
      bus.out_ready = mode == 0 || mode == 3 ? 1'b1 : mode == 1 ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      bus.start = mode == 3 && k == 20;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check("dump_finished", 64'(bus.busy), 0);
  endtask
  task automatic stall_at(input int idx);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid && bus.out_index == 5'(idx)) begin
        bus.out_ready = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL stall_timeout: index %0d never presented, required within 400 cycles", idx);
  endtask
  task automatic check_all_zero(input string name);
    check(name, 64'({bus.busy, bus.out_valid, bus.done, bus.out_index, bus.rd_addr}), 0);
    check({name, "_data"}, 64'(bus.out_data), 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) regs[i] = 32'(i) * 32'h1111_1111;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    // full dump, ready held high, cycle-exact done/busy
    push_dump();
    exp_done++;
    bus.out_ready = 1'b1;
    pulse_start();
    timing_on = 1'b1;
    finish_dump(0);
    repeat (3) @(posedge clk); #1;
    timing_on = 1'b0;
    check("t1_done_count", 64'(done_cnt), 64'(exp_done));
    check("t1_drained", 64'(q.size()), 0);
    // ready toggling 1,0,0
    push_dump();
    exp_done++;
    pulse_start();
    finish_dump(1);
    repeat (2) @(posedge clk); #1;
    check("t2_drained", 64'(q.size()), 0);
    // write x5 while stalled on index 3
    push_dump();
    exp_done++;
    pulse_start();
    stall_at(3);
    repeat (2) @(negedge clk);
    regs[5] = 32'hDEAD_BEEF;
    foreach (q[k]) if (q[k].idx == 5'd5) q[k].data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    finish_dump(0);
    repeat (2) @(posedge clk); #1;
    check("t3_drained", 64'(q.size()), 0);
    // abort while stalled on index 10
    push_dump();
    pulse_start();
    stall_at(10);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_outputs", 64'({bus.busy, bus.out_valid, bus.rd_addr}), 0);
    q.delete();
    repeat (3) @(posedge clk); #1;
    check("abort_no_done", 64'(done_cnt), 64'(exp_done));
    push_dump();
    exp_done++;
    pulse_start();
    finish_dump(0);
    repeat (2) @(posedge clk); #1;
    check("restart_drained", 64'(q.size()), 0);
    // stray start mid-dump and in the DONE cycle
    push_dump();
    exp_done++;
    pulse_start();
    finish_dump(3);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_in_done_ignored", 64'(bus.busy), 0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_idle", 64'({bus.busy, bus.out_valid}), 0);
    repeat (3) @(posedge clk); #1;
    check("start_abort_still_idle", 64'(bus.busy), 0);
    check("t5_drained", 64'(q.size()), 0);
    // asynchronous reset between edges on index 7
    push_dump();
    pulse_start();
    stall_at(7);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    repeat (3) @(posedge clk); #1;
    check("reset_no_done", 64'(done_cnt), 64'(exp_done));
    // random contents and random backpressure
    for (int r = 0; r < 3; r++) begin
      regs[0] = '0;
      for (int i = 1; i < N; i++) regs[i] = $urandom;
      push_dump();
      exp_done++;
      pulse_start();
      finish_dump(2);
      repeat (2) @(posedge clk); #1;
      check("rand_drained", 64'(q.size()), 0);
    end
    check("final_done_count", 64'(done_cnt), 64'(exp_done));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
